// File: rtl/incr_stream_gen.sv
// Multi-channel incrementing-pattern stream source with seed/length, round-robin channel
// interleaving and valid/ready back-pressure. Optional macro: INCR_STREAM_GEN_ERR_INJ_EN.
module incr_stream_gen #(
  parameter int          WIDTH  = 32,
  parameter int          NUM_CH = 1,
  parameter logic [31:0] STRIDE = 32'h0,
  parameter int          CNT_W  = 16,
  localparam int         CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] seed,
  input  logic [CNT_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef INCR_STREAM_GEN_ERR_INJ_EN
  input  logic             inj_err,
`endif
  output logic [WIDTH-1:0] out_data,
  output logic [CH_W-1:0]  out_chan,
  output logic             out_last
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  localparam logic [WIDTH-1:0] STRIDE_W = WIDTH'(STRIDE);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [WIDTH-1:0] acc_q [NUM_CH];
  logic [WIDTH-1:0] acc_d [NUM_CH];

  logic run, last_beat, hs;

  assign run       = (state_q == RUN);
  assign last_beat = (cnt_q == len_q - CNT_W'(1));
  assign hs        = run & out_ready;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d = len;
          cnt_d = '0;
          ch_d  = '0;
          for (int c = 0; c < NUM_CH; c++) begin
            acc_d[c] = seed + WIDTH'(c) * STRIDE_W;
          end
          state_d = (len != '0) ? RUN : FIN;
        end
      end
      RUN: begin
        if (hs) begin
          acc_d[ch_q] = acc_q[ch_q] + WIDTH'(1);
          ch_d        = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;
          cnt_d       = cnt_q + CNT_W'(1);
          if (last_beat) state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments only; combinational logic above uses blocking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
    end
  end

  // NOTE: the accumulator array is not reset; every start re-seeds it and out_data is gated outside RUN.
  always_ff @(posedge clk) begin
    acc_q <= acc_d;
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);
  assign out_valid = run;
  assign out_chan  = run ? ch_q : '0;
  assign out_last  = run & last_beat;

`ifdef INCR_STREAM_GEN_ERR_INJ_EN
  // Corruption is output-only; the accumulator keeps counting from the clean value.
  assign out_data  = run ? (acc_q[ch_q] ^ WIDTH'(inj_err)) : '0;
`else
  assign out_data  = run ? acc_q[ch_q] : '0;
`endif

endmodule

// File: tb/tb_incr_stream_gen.sv
// Bench for incr_stream_gen: a 1-channel and a 4-channel (STRIDE 0x100) instance share stimulus
// and are both compared against an arithmetic model of the beat sequence.
module tb_incr_stream_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] seed;
  logic [15:0] len;
  logic        out_ready;
`ifdef INCR_STREAM_GEN_ERR_INJ_EN
  logic        inj_err;
`endif

  logic        busy1, done1, valid1, last1;
  logic [31:0] data1;
  logic        chan1;
  logic        busy4, done4, valid4, last4;
  logic [31:0] data4;
  logic [1:0]  chan4;

  logic        busy_a [2];
  logic        done_a [2];
  logic        valid_a[2];
  logic        last_a [2];
  logic [31:0] data_a [2];
  logic [3:0]  chan_a [2];

  int errors = 0;
  int checks = 0;
  int ready_pat[$];

  always #5 clk = ~clk;

  incr_stream_gen #(.WIDTH(32), .NUM_CH(1), .STRIDE(32'h0), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .len(len),
    .busy(busy1), .done(done1), .out_valid(valid1), .out_ready(out_ready),
`ifdef INCR_STREAM_GEN_ERR_INJ_EN
    .inj_err(inj_err),
`endif
    .out_data(data1), .out_chan(chan1), .out_last(last1)
  );

  incr_stream_gen #(.WIDTH(32), .NUM_CH(4), .STRIDE(32'h100), .CNT_W(16)) dut4 (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .len(len),
    .busy(busy4), .done(done4), .out_valid(valid4), .out_ready(out_ready),
`ifdef INCR_STREAM_GEN_ERR_INJ_EN
    .inj_err(inj_err),
`endif
    .out_data(data4), .out_chan(chan4), .out_last(last4)
  );

  assign busy_a[0]  = busy1;  assign busy_a[1]  = busy4;
  assign done_a[0]  = done1;  assign done_a[1]  = done4;
  assign valid_a[0] = valid1; assign valid_a[1] = valid4;
  assign last_a[0]  = last1;  assign last_a[1]  = last4;
  assign data_a[0]  = data1;  assign data_a[1]  = data4;
  assign chan_a[0]  = 4'(chan1);
  assign chan_a[1]  = 4'(chan4);

  // Beat k goes to channel k mod nch; that channel has already emitted k/nch beats.
  function automatic logic [31:0] exp_data(input logic [31:0] sd, input int k, input int d);
    int nch = (d == 0) ? 1 : 4;
    logic [31:0] stride = (d == 0) ? 32'h0 : 32'h100;
    return sd + 32'(k % nch) * stride + 32'(k / nch);
  endfunction

  function automatic logic [3:0] exp_chan(input int k, input int d);
    return 4'(k % ((d == 0) ? 1 : 4));
  endfunction

  // poke_at: loop cycle at which a spurious start is driven (-1 none); inj_beat: beat to corrupt.
  task automatic run_burst(input string name, input logic [31:0] sd, input logic [15:0] ln,
                           input bit rnd, input int poke_at, input int inj_beat);
    int beats = 0;
    int cyc   = 0;
    int busy_cycles = 0;
    logic [31:0] ed;
    bit inj;
    @(negedge clk);
    start = 1'b1; seed = sd; len = ln;
    @(negedge clk);
    start = 1'b0; seed = $urandom; len = 16'($urandom);
    while (beats < int'(ln) && cyc < 400) begin
      if (ready_pat.size() > 0) out_ready = ready_pat.pop_front() != 0;
      else                      out_ready = rnd ? 1'($urandom) : 1'b1;
      if (cyc == poke_at) begin
        start = 1'b1; seed = 32'hdead0000; len = 16'd3;
      end else begin
        start = 1'b0;
      end
      inj = (beats == inj_beat);
`ifdef INCR_STREAM_GEN_ERR_INJ_EN
      inj_err = inj;
`endif
      for (int d = 0; d < 2; d++) begin
        ed = exp_data(sd, beats, d);
`ifdef INCR_STREAM_GEN_ERR_INJ_EN
        if (inj) ed = ed ^ 32'h1;
`endif
        checks++;
        if (valid_a[d] !== 1'b1 || data_a[d] !== ed || chan_a[d] !== exp_chan(beats, d) ||
            last_a[d] !== (beats == int'(ln) - 1) || busy_a[d] !== 1'b1 || done_a[d] !== 1'b0) begin
          errors++;
          $display("FAIL %s dut%0d beat %0d: got v=%b d=%h ch=%0d l=%b b=%b dn=%b want v=1 d=%h ch=%0d l=%b b=1 dn=0",
                   name, d, beats, valid_a[d], data_a[d], chan_a[d], last_a[d], busy_a[d], done_a[d],
                   ed, exp_chan(beats, d), (beats == int'(ln) - 1));
        end
      end
      if (out_ready) beats++;
      busy_cycles++;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
`ifdef INCR_STREAM_GEN_ERR_INJ_EN
    inj_err = 1'b0;
`endif
    if (cyc >= 400) begin
      errors++; checks++;
      $display("FAIL %s timeout: got %0d beats want %0d", name, beats, ln);
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (done_a[d] !== 1'b1 || busy_a[d] !== 1'b1 || valid_a[d] !== 1'b0 || last_a[d] !== 1'b0) begin
        errors++;
        $display("FAIL %s_fin dut%0d: got dn=%b b=%b v=%b l=%b want dn=1 b=1 v=0 l=0",
                 name, d, done_a[d], busy_a[d], valid_a[d], last_a[d]);
      end
    end
    busy_cycles++;
    if (!rnd) begin
      checks++;
      if (busy_cycles != int'(ln) + cyc - beats + 1) begin
        errors++;
        $display("FAIL %s_busy_len: got %0d want %0d", name, busy_cycles, int'(ln) + cyc - beats + 1);
      end
    end
    out_ready = 1'($urandom);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (done_a[d] !== 1'b0 || busy_a[d] !== 1'b0 || valid_a[d] !== 1'b0) begin
        errors++;
        $display("FAIL %s_idle dut%0d: got dn=%b b=%b v=%b want 0 0 0",
                 name, d, done_a[d], busy_a[d], valid_a[d]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; seed = '0; len = '0; out_ready = 1'b0;
`ifdef INCR_STREAM_GEN_ERR_INJ_EN
    inj_err = 1'b0;
`endif
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({busy_a[d], done_a[d], valid_a[d], last_a[d]} !== 4'b0 || data_a[d] !== 32'h0 || chan_a[d] !== 4'h0) begin
        errors++;
        $display("FAIL reset dut%0d: got b=%b dn=%b v=%b l=%b d=%h ch=%0d want all 0",
                 d, busy_a[d], done_a[d], valid_a[d], last_a[d], data_a[d], chan_a[d]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_single_channel();
    run_burst("cafe", 32'hcafedeca, 16'd10, 1'b0, -1, -1);
  endtask

  task automatic test_interleave();
    run_burst("interleave", 32'h0, 16'd8, 1'b0, -1, -1);
  endtask

  task automatic test_back_pressure();
    ready_pat = '{1, 0, 0, 1, 0, 1, 1};
    run_burst("backpressure", 32'h5, 16'd4, 1'b0, -1, -1);
  endtask

  task automatic test_edges();
    run_burst("wrap", 32'hffffffff, 16'd3, 1'b0, -1, -1);
    run_burst("len0", 32'h1234, 16'd0, 1'b0, -1, -1);
    run_burst("start_ignored", 32'h400, 16'd6, 1'b0, 2, -1);
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk);
    start = 1'b1; seed = $urandom; len = 16'd10; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({busy_a[d], done_a[d], valid_a[d], last_a[d]} !== 4'b0 || data_a[d] !== 32'h0 || chan_a[d] !== 4'h0) begin
        errors++;
        $display("FAIL rst_mid dut%0d: got b=%b dn=%b v=%b l=%b d=%h ch=%0d want all 0",
                 d, busy_a[d], done_a[d], valid_a[d], last_a[d], data_a[d], chan_a[d]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (done1 !== 1'b0 || done4 !== 1'b0 || busy1 !== 1'b0 || busy4 !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_nodone cyc %0d: got dn=%b%b b=%b%b want 00 00", i, done1, done4, busy1, busy4);
      end
    end
    run_burst("rst_restart", 32'h10, 16'd2, 1'b0, -1, -1);
  endtask

  task automatic test_err_inj();
    run_burst("err_inj", 32'h20, 16'd3, 1'b0, -1, 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      run_burst("random", $urandom, 16'($urandom_range(0, 24)), 1'b1,
                $urandom_range(0, 8) - 1, -1);
    end
  endtask

  initial begin
    test_reset();
    test_single_channel();
    test_interleave();
    test_back_pressure();
    test_edges();
    test_reset_mid_burst();
    test_err_inj();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/incr_stream_gen.md
Name: incr_stream_gen

Overview:
Parametrised multi-channel incrementing-pattern stream source for the foo interface test environment.
- Generalises the single-channel, fixed-width, fixed-count drive sequence into a configurable block.
- Adds programmable seed and length, channel interleaving, valid/ready back-pressure and start/done control.
- Sits between the test sequencer and the foo bus driver; its output feeds a bus monitor.

Parameters:
- WIDTH, 32, data width in bits.
- NUM_CH, 1, number of interleaved channels (1..16).
- STRIDE, 32'h0, per-channel seed offset: channel c starts at seed + c*STRIDE (mod 2^WIDTH).
- CNT_W, 16, width of the beat-length field.

Ports:
- clk  input  1  clock, all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  begin burst; sampled only in IDLE.
- seed  input  WIDTH  base value; sampled with start.
- len  input  CNT_W  total beats in the burst across all channels; sampled with start.
- busy  output  1  high from the cycle after an accepted start until the done pulse, inclusive.
- done  output  1  single-cycle pulse at burst completion.
- out_valid  output  1  beat valid.
- out_ready  input  1  sink accepts beat.
- out_data  output  WIDTH  beat payload.
- out_chan  output  max(1,$clog2(NUM_CH))  channel of the current beat.
- out_last  output  1  high on the final beat of the burst.

Behaviour:
- Reset: on rst high at a clk edge, state goes to IDLE. busy, done, out_valid, out_last, out_data and out_chan are all 0. This applies mid-burst; the burst is abandoned and no done is generated.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - start=1 latches seed and len.
  - Channel accumulators init: acc[c] = seed + c*STRIDE.
  - Beat counter is cleared and cur_ch = 0.
  - Next state: RUN if len != 0, else FIN (no beats are emitted).
- RUN:
  - out_valid=1, out_data=acc[cur_ch], out_chan=cur_ch, out_last = (beat_cnt == len-1).
  - Handshake = out_valid & out_ready. On a handshake:
    - acc[cur_ch] += 1, wrapping mod 2^WIDTH.
    - cur_ch advances round-robin, with NUM_CH-1 wrapping to 0.
    - beat_cnt increments.
  - The handshake on the out_last beat moves the FSM to FIN; out_valid drops in the next cycle.
  - Stability: while out_valid=1 and out_ready=0, out_data, out_chan and out_last hold unchanged.
- FIN: done=1 and busy=1 for one cycle, then IDLE.
- start while busy is ignored. Inputs seed/len are don't-care outside the start cycle.
- Latency: first beat is valid the cycle after start. With out_ready held at 1, beats are back-to-back and done follows 1 cycle after the last beat. Total cycles from start to done = len+1.
- Burst length 0: done pulses the cycle after start and out_valid never asserts.
- Round-robin position and accumulators do not carry across bursts; each start re-seeds them.

Optional Feature:
Macro: INCR_STREAM_GEN_ERR_INJ_EN.
- Defined:
  - Adds input port inj_err (1 bit).
  - If inj_err=1 in the cycle of a handshake, that beat's out_data is presented with bit 0 inverted. The inversion is combinational on the output and applies while inj_err is high.
  - acc is still updated from the uncorrupted value, so later beats are correct.
  - Used to prove downstream monitors flag errors.
- Undefined: the port does not exist and out_data always equals the accumulator.

Test Plan:
- WIDTH=32, NUM_CH=1, seed=32'hcafedeca, len=10, ready=1 -> 10 consecutive beats 0xcafedeca..0xcafeded3; out_last on 0xcafeded3; done one cycle later; busy high for 11 cycles.
- NUM_CH=4, STRIDE=32'h100, seed=0, len=8, ready=1 -> data 0,100,200,300,1,101,201,301 (hex); out_chan 0,1,2,3,0,1,2,3; out_last on the 8th beat.
- Back-pressure: NUM_CH=1, seed=5, len=4, ready pattern 1,0,0,1,0,1,1 -> beats 5,6,7,8 accepted. Data holds 6 during both stall cycles; done after the 4th accept.
- Wrap and edge cases:
  - seed=32'hffffffff, len=3 -> ffffffff,00000000,00000001.
  - len=0 -> no out_valid; done exactly one cycle after start.
  - start asserted mid-burst is ignored.
- Reset mid-burst: assert rst after 3 of 10 beats -> all outputs 0 next cycle, no done. A new start with seed=0x10, len=2 then yields 0x10,0x11.
- With INCR_STREAM_GEN_ERR_INJ_EN: seed=0x20, len=3, inj_err on the 2nd handshake -> data 0x20,0x20,0x22 (0x21 with bit 0 flipped); without the macro the same stimulus yields 0x20,0x21,0x22.
